nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle controller that performs a WIDTH-bit addition by time-multiplexing a single 4-bit ripple-carry slice, one nibble per clock, least-significant nibble first. Carry is kept in a register between cycles, so area is that of one 4-bit adder regardless of operand width. The block sits between a valid/ready producer of operand pairs and a valid/ready consumer of sums. It is the sequenced, shared-datapath counterpart to the combinational 4-bit adder.

## Interface
- `WIDTH`, default 16: operand and sum width. Must be a multiple of 4 and at least 4.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: an operand pair is offered.
- `in_ready` output 1: the block can accept a pair; equals `state==IDLE`.
- `in_a` input WIDTH: operand A, sampled on accept.
- `in_b` input WIDTH: operand B, sampled on accept.
- `in_cin` input 1: carry-in, sampled on accept.
- `out_valid` output 1: the result is held; equals `state==DONE`.
- `out_ready` input 1: the consumer takes the result.
- `out_sum` output WIDTH: registered sum `(a+b+cin) mod 2^WIDTH`.
- `out_cout` output 1: registered carry-out of the MSB slice.

## Operation
- N = WIDTH/4 slices. Internal registers:
  - `a_q`, `b_q` (WIDTH each)
  - `carry_q` (1)
  - `idx_q` (ceil(log2 N), min 1 bit)
  - `sum_q`, `cout_q`
- FSM states: IDLE, RUN, DONE.
- **IDLE:**
  - When `in_valid & in_ready`, latch `in_a`, `in_b` into `a_q`, `b_q`, and `in_cin` into `carry_q`.
  - Set `idx_q=0` and go to RUN.
  - `sum_q` and `cout_q` keep their old values.
- **RUN:** each cycle the slice adds `a_q[4*idx+:4]`, `b_q[4*idx+:4]` and `carry_q`.
  - Write the slice sum into `sum_q[4*idx+:4]` and the slice carry into `carry_q`.
  - If `idx_q==N-1`: write the slice carry to `cout_q` and go to DONE. Otherwise increment `idx_q`.
- **DONE:** `out_valid=1`. `out_sum` and `out_cout` are held stable until `out_ready`. On `out_valid & out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE. Changes on `in_a`, `in_b` and `in_cin` after the accept edge have no effect on the result.
- Width rule: all slice arithmetic is 4+4+1 bits giving 5 bits. No sign handling; overflow is visible only via `out_cout`.
- **Reset (asynchronous, any state, including mid-RUN):**
  - Go to IDLE.
  - `a_q`, `b_q`, `sum_q`, `idx_q` all cleared to 0; `carry_q=0`, `cout_q=0`.
  - An in-flight operation is discarded and produces no output.
- **Output values while `rst_n` is low and after release:** `in_ready=1`, `out_valid=0`, `out_sum=0`, `out_cout=0`.

## Timing
- Accept edge E0. RUN occupies edges E1..EN. `out_valid` goes high after EN, i.e. N cycles after the accept edge. For WIDTH=16 that is 4 cycles.
- The result is available in the cycle after EN. There is no combinational path from any input to any output; `in_ready` and `out_valid` are decoded from registered state only.
- Minimum initiation interval: N+2 cycles (accept, N RUN cycles, one DONE cycle with `out_ready=1`, IDLE). A new pair is accepted in the cycle after the output handshake, not in the same cycle.
- Backpressure: DONE persists indefinitely while `out_ready=0`, and `in_ready` stays 0 throughout.
- `out_ready` is don't-care outside DONE.
- WIDTH=4 boundary case: N=1, one RUN cycle, `idx_q` never increments.

## Structure
- Shared package `nibble_adder_pkg` contains:
  - the state enum (IDLE, RUN, DONE)
  - the constant `SLICE_W=4`
- One sub-module, `adder_slice4`, is instantiated exactly once.
  - Inputs: `a[3:0]`, `b[3:0]`, `cin`.
  - Outputs: `s[3:0]`, `cout`.
  - Purely combinational, built from 4 chained per-bit full-adder equations.
- The top level holds the FSM, index counter, operand/sum registers and slice muxing.

## Test plan
- **Basic add (WIDTH=16):** `a=0x1234`, `b=0x1111`, `cin=0` -> `out_sum=0x2345`, `out_cout=0`; `out_valid` rises exactly 4 cycles after the accept edge.
- **Full carry ripple:** `a=0xFFFF`, `b=0x0000`, `cin=1` -> `out_sum=0x0000`, `out_cout=1`.
- **Backpressure:** `a=0x00FF`, `b=0x0001`, then hold `out_ready=0` for 5 cycles -> `out_valid=1`, `out_sum=0x0100` stable throughout; `in_ready=0`; a pair offered meanwhile is not accepted.
- **Input isolation:** after accepting `0x0F0F+0x0101`, drive `in_a`/`in_b` to random values and keep `in_valid=1` during RUN -> result `0x1010`, `cout=0`; exactly one result is produced.
- **Reset mid-RUN:** pulse `rst_n` low 2 cycles after the accept edge -> immediately `in_ready=1`, `out_valid=0`, `out_sum=0`, `out_cout=0`; a following `0x0001+0x0001` gives `0x0002`.
- **Back-to-back with `out_ready` tied 1:** `0x8000+0x8000` -> `0x0000`, `cout=1`; the next pair is accepted 6 cycles after the first accept; `0x7FFF+0x0001` -> `0x8000`, `cout=0`.

Source files
------------

// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_slice4.sv
// 4-bit ripple-carry slice built from chained per-bit full-adder equations.
module adder_slice4
    import nibble_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W:0] c;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[SLICE_W];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit slice, one nibble per clock, LSB nibble first,
// with valid/ready handshakes on both the operand and result sides.
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, sum_q;
    logic               carry_q, cout_q;
    logic [IDX_W-1:0]   idx_q;

    logic               load, step, last;
    logic [SLICE_W-1:0] a_nib, b_nib, s_nib;
    logic               c_nib;

    // State register
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        load      = in_ready & in_valid;
        step      = (state_q == RUN);
    end

    assign last = (idx_q == LAST_IDX);

    // Select the active nibble of each operand
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[i*SLICE_W +: SLICE_W];
                b_nib = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    adder_slice4 u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (s_nib),
        .cout (c_nib)
    );

    // Operand, carry, index and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, so out_sum/out_cout read 0 from reset.
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else if (load) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= in_cin;
            idx_q   <= '0;
        end else if (step) begin
            carry_q <= c_nib;
            for (int i = 0; i < N; i++) begin
                if (idx_q == IDX_W'(i)) sum_q[i*SLICE_W +: SLICE_W] <= s_nib;
            end
            if (last) cout_q <= c_nib;
            else      idx_q  <= idx_q + IDX_W'(1);
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16) with a result scoreboard queue.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
    } result_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    result_t sb[$];
    int      total = 0;
    int      passed = 0;
    int      cyc = 0;
    int      accept_cyc = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic result_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic cin);
        logic [WIDTH:0] full;
        full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        return '{sum: full[WIDTH-1:0], cout: full[WIDTH]};
    endfunction

    // Offer a pair at a negedge and wait for its accept edge; optionally keep in_valid high.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input bit hold);
        int k = 0;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        while (!in_ready && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("send_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back(model(a, b, cin));
        @(posedge clk);
        @(negedge clk);
        accept_cyc = cyc;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!out_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_timeout"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic compare_head(input string tag);
        result_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_sum"}, {16'd0, out_sum}, {16'd0, e.sum});
            check({tag, "_cout"}, {31'd0, out_cout}, {31'd0, e.cout});
        end
    endtask

    task automatic take(input string tag);
        compare_head(tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int      k;
        int      a1, a2;
        bit      seen, got1;

        // Reset values, while asserted and after release
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {16'd0, out_sum}, 32'd0);
        check("rst_out_cout", {31'd0, out_cout}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        check("rel_out_valid", {31'd0, out_valid}, 32'd0);

        // Basic add with latency check
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        wait_valid("basic");
        check("basic_latency", cyc - accept_cyc, 32'd4);
        check("basic_expected_const", {16'd0, sb[0].sum}, 32'h2345);
        take("basic");

        // Full carry ripple
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        wait_valid("ripple");
        take("ripple");

        // Backpressure: result held, new pair refused
        send(16'h00FF, 16'h0001, 1'b0, 1'b0);
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = 16'hAAAA; in_b = 16'h5555;
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_sum", {16'd0, out_sum}, 32'h0100);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        take("bp");
        seen = 1'b0;
        repeat (6) begin
            seen |= out_valid;
            @(negedge clk);
        end
        check("bp_not_accepted", {31'd0, seen}, 32'd0);

        // Input isolation: inputs scrambled and in_valid held during RUN
        send(16'h0F0F, 16'h0101, 1'b0, 1'b1);
        k = 0;
        while (!out_valid && k < 30) begin
            in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
            @(negedge clk);
            k++;
        end
        check("iso_timeout", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        take("iso");
        seen = 1'b0;
        repeat (8) begin
            seen |= out_valid;
            @(negedge clk);
        end
        check("iso_single_result", {31'd0, seen}, 32'd0);

        // Reset in the middle of RUN discards the operation
        send(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_sum", {16'd0, out_sum}, 32'd0);
        check("mid_rst_out_cout", {31'd0, out_cout}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        send(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_valid("post_rst");
        take("post_rst");

        // Back-to-back with out_ready tied high
        out_ready = 1'b1;
        send(16'h8000, 16'h8000, 1'b0, 1'b0);
        a1 = accept_cyc;
        in_a = 16'h7FFF; in_b = 16'h0001; in_cin = 1'b0; in_valid = 1'b1;
        got1 = 1'b0;
        k = 0;
        while (k < 30) begin
            if (in_ready && got1) break;
            if (out_valid && !got1) begin
                compare_head("b2b_first");
                got1 = 1'b1;
            end
            @(negedge clk);
            k++;
        end
        check("b2b_first_seen", {31'd0, got1}, 32'd1);
        sb.push_back(model(16'h7FFF, 16'h0001, 1'b0));
        @(posedge clk);
        @(negedge clk);
        a2 = cyc;
        in_valid = 1'b0;
        check("b2b_interval", a2 - a1, 32'd6);
        wait_valid("b2b_second");
        compare_head("b2b_second");
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_idle_after", {31'd0, in_ready}, 32'd1);
        check("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
